cop0_masked_regfile: RTL and testbench
======================================

// Module: cop0_masked_regfile
// PURPOSE
//  Parametrised COP0 register bank: holds BadVAddr, Count, Compare, Status, Cause, EPC, EBase, LLAddr.
//  MTC0 writes are merged through per-register write masks; exception/ERET/timer/IRQ hardware updates
//  bypass the masks. Sits in the memory stage beside the GPR file; feeds the exception unit and fetch.
// PARAMETERS
//  STATUS_WMASK  32'h1040FF17  MTC0-writable bits of Status (1 = writable)
//  CAUSE_WMASK   32'h00800300  MTC0-writable bits of Cause (IV, IP1:0)
//  EBASE_WMASK   32'h3FFFF000  MTC0-writable bits of EBase (sel 1)
//  STATUS_RST    32'h00400004  Status reset value (BEV=1, ERL=1)
//  EBASE_RST     32'h80000000  EBase reset value
//  COUNT_DIV     2             clocks per Count increment (>=1)
// PORTS
//  clk           in   1   clock
//  reset         in   1   asynchronous, active-high reset
//  rd            in   5   COP0 register number (read and MTC0 write)
//  sel           in   3   COP0 select
//  we            in   1   MTC0 write strobe
//  wdata         in   32  MTC0 write data
//  rdata         out  32  combinational read of (rd,sel); 0 for unmapped
//  exc_valid     in   1   exception commit
//  exc_code      in   5   Cause.ExcCode value
//  exc_bd        in   1   faulting instr in branch delay slot
//  exc_epc       in   32  restart PC
//  exc_bva_valid in   1   exception carries bad address
//  exc_bva       in   32  bad virtual address
//  eret          in   1   ERET commit
//  ll_valid      in   1   LL commit
//  ll_addr       in   32  LL physical address
//  hw_irq        in   6   external interrupts -> Cause.IP7:2 (level)
//  status_o/cause_o/epc_o/ebase_o  out 32 each  current register values
//  irq_pending   out  1   IE & ~EXL & ~ERL & |(Cause.IP & Status.IM)
// BEHAVIOUR
//  Map (rd/sel): BadVAddr 8/0, Count 9/0, Compare 11/0, Status 12/0, Cause 13/0, EPC 14/0,
//   EBase 15/1, LLAddr 17/0. Any other pair: read 0, write ignored. BadVAddr, LLAddr: MTC0 read-only.
//  Reset: Status=STATUS_RST, EBase=EBASE_RST, all others 0, divider 0; irq_pending=0.
//  MTC0 (we, no exc_valid): reg <= (reg & ~M) | (wdata & M); Count/Compare/EPC use M=all-ones.
//   Takes effect next cycle; rdata same cycle shows old value (no bypass).
//  Count: divider counts 0..COUNT_DIV-1; on wrap Count+1 (mod 2^32). MTC0 Count wins over increment
//   and resets divider.
//  Timer: when Count increments to a value equal to Compare, set Cause.TI(30); Cause.IP7 = hw_irq[5] | TI.
//   MTC0 Compare clears TI; if same cycle as a match, clear wins.
//  Cause.IP7:2 resampled every cycle from hw_irq (registered, 1-cycle latency); IP1:0 MTC0 only.
//  Exception (exc_valid): ExcCode<=exc_code; if Status.EXL==0: EPC<=exc_epc, Cause.BD<=exc_bd;
//   if EXL==1: EPC and BD unchanged. Status.EXL<=1. BadVAddr<=exc_bva if exc_bva_valid.
//   Same-cycle MTC0 is discarded (instruction squashed). Count/timer still update.
//  ERET: if ERL, clear ERL; else clear EXL. exc_valid wins over same-cycle eret.
//  LL: LLAddr <= ll_addr>>4 on ll_valid.
//  irq_pending combinational from registered Status/Cause.
// TESTING
//  Reset -> Status=0x00400004, EBase=0x80000000, Cause=0, Count=0, irq_pending=0.
//  MTC0 Status=0xFFFFFFFF -> reads 0x1040FF17; MTC0 Cause=0xFFFFFFFF -> reads 0x00800300 (IP7:2=hw_irq).
//  Compare=5, Count=3, COUNT_DIV=2 -> TI=1 after 4 clocks; MTC0 Compare clears TI next cycle.
//  exc_valid(code 4,epc 0x1000,bva 0x13) with EXL=0 -> EPC=0x1000, ExcCode=4, EXL=1; second exc epc 0x2000 keeps EPC.
//  exc_valid + we to EPC same cycle -> EPC=exc_epc; exc_valid + eret -> EXL=1.
//  IE=1, IM2=1, hw_irq[0]=1, EXL=ERL=0 -> irq_pending=1 two cycles later; assert reset mid-timer -> all reset values.

Source files
------------

// File: rtl/cop0_masked_regfile_if.sv
// cop0_masked_regfile_if
//   Bundles the COP0 register bank's access and update signals.
//   master : memory-stage / exception-unit side (drives requests, sees state)
//   slave  : the register bank itself
//   Signals:
//     rd, sel, we, wdata, rdata          MTC0 write / MFC0 read port
//     exc_valid, exc_code, exc_bd,
//     exc_epc, exc_bva_valid, exc_bva    exception commit
//     eret                               ERET commit
//     ll_valid, ll_addr                  LL commit
//     hw_irq                             external interrupt levels
//     status_o, cause_o, epc_o, ebase_o  current register values
//     irq_pending                        interrupt request to the exception unit
interface cop0_masked_regfile_if;
  logic [4:0]  rd;
  logic [2:0]  sel;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic        exc_bva_valid;
  logic [31:0] exc_bva;
  logic        eret;
  logic        ll_valid;
  logic [31:0] ll_addr;
  logic [5:0]  hw_irq;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] ebase_o;
  logic        irq_pending;

  modport master (
    output rd, sel, we, wdata,
    output exc_valid, exc_code, exc_bd, exc_epc, exc_bva_valid, exc_bva,
    output eret, ll_valid, ll_addr, hw_irq,
    input  rdata, status_o, cause_o, epc_o, ebase_o, irq_pending
  );

  modport slave (
    input  rd, sel, we, wdata,
    input  exc_valid, exc_code, exc_bd, exc_epc, exc_bva_valid, exc_bva,
    input  eret, ll_valid, ll_addr, hw_irq,
    output rdata, status_o, cause_o, epc_o, ebase_o, irq_pending
  );
endinterface

// File: rtl/cop0_masked_regfile.sv
// cop0_masked_regfile
//   COP0 register bank: BadVAddr, Count, Compare, Status, Cause, EPC, EBase,
//   LLAddr. MTC0 writes merge through per-register write masks; exception,
//   ERET, timer and interrupt updates are applied directly.
//   Ports:
//     clk    clock
//     reset  asynchronous, active-high reset
//     bus    cop0_masked_regfile_if.slave (access port, commits, state outputs)
module cop0_masked_regfile #(
  parameter logic [31:0] STATUS_WMASK = 32'h1040FF17,
  parameter logic [31:0] CAUSE_WMASK  = 32'h00800300,
  parameter logic [31:0] EBASE_WMASK  = 32'h3FFFF000,
  parameter logic [31:0] STATUS_RST   = 32'h00400004,
  parameter logic [31:0] EBASE_RST    = 32'h80000000,
  parameter int unsigned COUNT_DIV    = 2
) (
  input logic                  clk,
  input logic                  reset,
  cop0_masked_regfile_if.slave bus
);

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  // {rd, sel} codes of the mapped registers
  localparam logic [7:0] A_BVA    = {5'd8,  3'd0};
  localparam logic [7:0] A_COUNT  = {5'd9,  3'd0};
  localparam logic [7:0] A_CMP    = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE  = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC    = {5'd14, 3'd0};
  localparam logic [7:0] A_EBASE  = {5'd15, 3'd1};
  localparam logic [7:0] A_LL     = {5'd17, 3'd0};

  logic [31:0]      bva_q, bva_d;
  logic [31:0]      count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      cmp_q, cmp_d;
  logic [31:0]      status_q, status_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      ebase_q, ebase_d;
  logic [31:0]      ll_q, ll_d;
  logic             ti_q, ti_d;
  logic             bd_q, bd_d;
  logic             iv_q, iv_d;
  logic [1:0]       ip_sw_q, ip_sw_d;
  logic [4:0]       exc_code_q, exc_code_d;
  logic [5:0]       ip_hw_q;

  logic [7:0]  addr;
  logic        mtc;
  logic        wr_count, wr_cmp, wr_status, wr_cause, wr_epc, wr_ebase;
  logic        count_inc;
  logic [31:0] cause_w;
  logic [31:0] cause_m;
  logic        unused_ok;

  assign addr = {bus.rd, bus.sel};
  // A committing exception squashes the instruction carrying the MTC0.
  assign mtc  = bus.we & ~bus.exc_valid;

  assign wr_count  = mtc & (addr == A_COUNT);
  assign wr_cmp    = mtc & (addr == A_CMP);
  assign wr_status = mtc & (addr == A_STATUS);
  assign wr_cause  = mtc & (addr == A_CAUSE);
  assign wr_epc    = mtc & (addr == A_EPC);
  assign wr_ebase  = mtc & (addr == A_EBASE);

  // IP7 carries the timer interrupt ORed onto external line 5.
  assign cause_w = {bd_q, ti_q, 6'b0, iv_q, 7'b0,
                    ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q,
                    1'b0, exc_code_q, 2'b0};

  // Masked merge of an MTC0 into Cause; only the software-owned fields are kept.
  assign cause_m = (cause_w & ~CAUSE_WMASK) | (bus.wdata & CAUSE_WMASK);

  assign unused_ok = ^{bus.ll_addr[3:0], cause_m[30:24], cause_m[22:10],
                       cause_m[7], cause_m[1:0]};

  // Count / divider / timer
  always_comb begin
    div_d     = div_q;
    count_d   = count_q;
    count_inc = 1'b0;
    if (wr_count) begin
      count_d = bus.wdata;
      div_d   = '0;
    end else if (div_q == DIV_LAST) begin
      div_d     = '0;
      count_d   = count_q + 32'd1;
      count_inc = 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end

    cmp_d = cmp_q;
    ti_d  = ti_q;
    if (count_inc && (count_d == cmp_q)) ti_d = 1'b1;
    // A Compare write acknowledges the timer, even against a same-cycle match.
    if (wr_cmp) begin
      cmp_d = bus.wdata;
      ti_d  = 1'b0;
    end
  end

  // Status / Cause / EPC / BadVAddr / EBase / LLAddr
  always_comb begin
    status_d = status_q;
    if (wr_status) status_d = (status_q & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK);
    if (bus.exc_valid) begin
      status_d[1] = 1'b1;
    end else if (bus.eret) begin
      // ERL takes precedence over EXL on return.
      if (status_q[2]) status_d[2] = 1'b0;
      else             status_d[1] = 1'b0;
    end

    bd_d       = bd_q;
    iv_d       = iv_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    if (wr_cause) begin
      bd_d       = cause_m[31];
      iv_d       = cause_m[23];
      ip_sw_d    = cause_m[9:8];
      exc_code_d = cause_m[6:2];
    end

    epc_d = epc_q;
    if (wr_epc) epc_d = bus.wdata;

    // Nested exception (EXL already set) keeps the original EPC and BD.
    if (bus.exc_valid) begin
      exc_code_d = bus.exc_code;
      if (!status_q[1]) begin
        epc_d = bus.exc_epc;
        bd_d  = bus.exc_bd;
      end
    end

    bva_d = bva_q;
    if (bus.exc_valid && bus.exc_bva_valid) bva_d = bus.exc_bva;

    ebase_d = ebase_q;
    if (wr_ebase) ebase_d = (ebase_q & ~EBASE_WMASK) | (bus.wdata & EBASE_WMASK);

    ll_d = ll_q;
    if (bus.ll_valid) ll_d = {4'b0, bus.ll_addr[31:4]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bva_q      <= '0;
      count_q    <= '0;
      div_q      <= '0;
      cmp_q      <= '0;
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      ebase_q    <= EBASE_RST;
      ll_q       <= '0;
      ti_q       <= 1'b0;
      bd_q       <= 1'b0;
      iv_q       <= 1'b0;
      ip_sw_q    <= '0;
      exc_code_q <= '0;
      ip_hw_q    <= '0;
    end else begin
      bva_q      <= bva_d;
      count_q    <= count_d;
      div_q      <= div_d;
      cmp_q      <= cmp_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      ebase_q    <= ebase_d;
      ll_q       <= ll_d;
      ti_q       <= ti_d;
      bd_q       <= bd_d;
      iv_q       <= iv_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      ip_hw_q    <= bus.hw_irq;
    end
  end

  // Read port shows registered values only (no write bypass).
  always_comb begin
    bus.rdata = '0;
    case (addr)
      A_BVA:    bus.rdata = bva_q;
      A_COUNT:  bus.rdata = count_q;
      A_CMP:    bus.rdata = cmp_q;
      A_STATUS: bus.rdata = status_q;
      A_CAUSE:  bus.rdata = cause_w;
      A_EPC:    bus.rdata = epc_q;
      A_EBASE:  bus.rdata = ebase_q;
      A_LL:     bus.rdata = ll_q;
      default:  bus.rdata = '0;
    endcase
  end

  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_w;
  assign bus.epc_o       = epc_q;
  assign bus.ebase_o     = ebase_q;
  assign bus.irq_pending = status_q[0] & ~status_q[1] & ~status_q[2]
                         & (|(cause_w[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cop0_masked_regfile.sv
module tb_cop0_masked_regfile;

  localparam logic [31:0] SM   = 32'h1040FF17;
  localparam logic [31:0] CM   = 32'h00800300;
  localparam logic [31:0] EM   = 32'h3FFFF000;
  localparam int          CDIV = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cop0_masked_regfile_if bus ();

  cop0_masked_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_bva, m_count, m_cmp, m_status, m_epc, m_ebase, m_ll;
  logic [31:0] m_csw;   // software/exception-owned Cause bits: BD, IV, IP1:0, ExcCode
  int          m_div;   // clocks elapsed since the last Count increment
  logic        m_ti;
  logic [5:0]  m_hw;

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c          = m_csw;
    c[30]      = m_ti;
    c[15:10]   = m_hw;
    c[15]      = m_hw[5] | m_ti;
    return c;
  endfunction

  function automatic logic m_irq();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] && !m_status[1] && !m_status[2] && ((c[15:8] & m_status[15:8]) != 8'h0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r, input logic [2:0] s);
    if (s == 3'd0) begin
      case (r)
        5'd8:  return m_bva;
        5'd9:  return m_count;
        5'd11: return m_cmp;
        5'd12: return m_status;
        5'd13: return m_cause();
        5'd14: return m_epc;
        5'd17: return m_ll;
        default: return 32'h0;
      endcase
    end
    if (s == 3'd1 && r == 5'd15) return m_ebase;
    return 32'h0;
  endfunction

  function automatic logic hit(input int r, input int s);
    return (32'(bus.rd) == r) && (32'(bus.sel) == s);
  endfunction

  task automatic m_reset();
    m_bva = 0; m_count = 0; m_cmp = 0; m_status = 32'h00400004;
    m_epc = 0; m_ebase = 32'h80000000; m_ll = 0; m_csw = 0;
    m_div = 0; m_ti = 0; m_hw = 0;
  endtask

  task automatic model_step();
    logic        mtc, inc, n_ti;
    logic [31:0] n_count, n_cmp, n_status, n_csw, n_epc;
    int          n_div;
    mtc = bus.we && !bus.exc_valid;
    inc = 1'b0;
    n_count = m_count;
    n_div   = m_div;
    if (mtc && hit(9, 0)) begin
      n_count = bus.wdata; n_div = 0;
    end else if (m_div + 1 == CDIV) begin
      n_div = 0; n_count = m_count + 32'd1; inc = 1'b1;
    end else begin
      n_div = m_div + 1;
    end
    n_ti  = m_ti || (inc && n_count == m_cmp);
    n_cmp = m_cmp;
    if (mtc && hit(11, 0)) begin n_cmp = bus.wdata; n_ti = 1'b0; end

    n_status = m_status;
    if (mtc && hit(12, 0)) n_status = (m_status & ~SM) | (bus.wdata & SM);
    n_csw = m_csw;
    if (mtc && hit(13, 0)) n_csw = (m_csw & ~CM) | (bus.wdata & CM);
    n_epc = m_epc;
    if (mtc && hit(14, 0)) n_epc = bus.wdata;
    if (mtc && hit(15, 1)) m_ebase = (m_ebase & ~EM) | (bus.wdata & EM);

    if (bus.exc_valid) begin
      n_status[1] = 1'b1;
      n_csw[6:2]  = bus.exc_code;
      if (!m_status[1]) begin
        n_epc      = bus.exc_epc;
        n_csw[31]  = bus.exc_bd;
      end
      if (bus.exc_bva_valid) m_bva = bus.exc_bva;
    end else if (bus.eret) begin
      if (m_status[2]) n_status[2] = 1'b0;
      else             n_status[1] = 1'b0;
    end
    if (bus.ll_valid) m_ll = bus.ll_addr >> 4;

    m_count = n_count; m_div = n_div; m_ti = n_ti; m_cmp = n_cmp;
    m_status = n_status; m_csw = n_csw; m_epc = n_epc;
    m_hw = bus.hw_irq;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rdata",  bus.rdata,    m_read(bus.rd, bus.sel));
    chk("status", bus.status_o, m_status);
    chk("cause",  bus.cause_o,  m_cause());
    chk("epc",    bus.epc_o,    m_epc);
    chk("ebase",  bus.ebase_o,  m_ebase);
    chk("irq",    32'(bus.irq_pending), 32'(m_irq()));
  endtask

  // Check at the falling edge, advance the model, cross the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    if (reset) m_reset();
    else       model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd = 0; bus.sel = 0; bus.we = 0; bus.wdata = 0;
    bus.exc_valid = 0; bus.exc_code = 0; bus.exc_bd = 0; bus.exc_epc = 0;
    bus.exc_bva_valid = 0; bus.exc_bva = 0; bus.eret = 0;
    bus.ll_valid = 0; bus.ll_addr = 0;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
    bus.rd = r; bus.sel = s; bus.we = 1'b1; bus.wdata = d;
    cycle();
    bus.we = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] r, input logic [2:0] s,
                          input logic [31:0] exp);
    bus.rd = r; bus.sel = s;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  logic [7:0] pairs [10] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68,
                             8'h70, 8'h79, 8'h88, 8'h78, 8'h61};

  initial begin
    logic [7:0] pr;
    reset = 1'b1;
    idle();
    bus.hw_irq = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_status", bus.status_o, 32'h00400004);
    chk("rst_ebase",  bus.ebase_o,  32'h80000000);
    chk("rst_cause",  bus.cause_o,  32'h0);
    chk("rst_irq",    32'(bus.irq_pending), 32'h0);
    read_chk("rst_count", 5'd9, 3'd0, 32'h0);
    reset = 1'b0;

    // write masks
    mtc0(5'd12, 3'd0, 32'hFFFFFFFF);
    chk("status_mask", bus.status_o, 32'h1040FF17);
    mtc0(5'd13, 3'd0, 32'hFFFFFFFF);
    chk("cause_mask", bus.cause_o, 32'h00800300);
    mtc0(5'd15, 3'd1, 32'hFFFFFFFF);
    chk("ebase_mask", bus.ebase_o, 32'hBFFFF000);
    mtc0(5'd8, 3'd0, 32'h12345678);
    read_chk("bva_ro", 5'd8, 3'd0, 32'h0);
    mtc0(5'd12, 3'd7, 32'h0);
    chk("unmapped_wr", bus.status_o, 32'h1040FF17);

    // timer
    mtc0(5'd11, 3'd0, 32'd5);
    mtc0(5'd9, 3'd0, 32'd3);
    repeat (3) cycle();
    chk("ti_early", 32'(bus.cause_o[30]), 32'h0);
    cycle();
    chk("ti_set", 32'(bus.cause_o[30]), 32'h1);
    chk("ip7_ti", 32'(bus.cause_o[15]), 32'h1);
    read_chk("count_at_ti", 5'd9, 3'd0, 32'd5);
    mtc0(5'd11, 3'd0, 32'h100);
    chk("ti_clr", 32'(bus.cause_o[30]), 32'h0);

    // exceptions
    mtc0(5'd12, 3'd0, 32'h0);
    bus.exc_valid = 1; bus.exc_code = 5'd4; bus.exc_epc = 32'h1000;
    bus.exc_bva_valid = 1; bus.exc_bva = 32'h13;
    cycle();
    idle();
    chk("exc_epc", bus.epc_o, 32'h1000);
    chk("exc_code", 32'(bus.cause_o[6:2]), 32'd4);
    chk("exc_exl", 32'(bus.status_o[1]), 32'h1);
    read_chk("exc_bva", 5'd8, 3'd0, 32'h13);
    bus.exc_valid = 1; bus.exc_code = 5'd5; bus.exc_epc = 32'h2000;
    cycle();
    idle();
    chk("nested_epc", bus.epc_o, 32'h1000);
    chk("nested_code", 32'(bus.cause_o[6:2]), 32'd5);
    bus.eret = 1;
    cycle();
    idle();
    chk("eret_exl", 32'(bus.status_o[1]), 32'h0);
    bus.exc_valid = 1; bus.exc_epc = 32'h3000;
    bus.we = 1; bus.rd = 5'd14; bus.wdata = 32'hDEADBEEF;
    cycle();
    idle();
    chk("exc_over_mtc", bus.epc_o, 32'h3000);
    bus.eret = 1;
    cycle();
    bus.eret = 1; bus.exc_valid = 1;
    cycle();
    idle();
    chk("exc_over_eret", 32'(bus.status_o[1]), 32'h1);
    bus.eret = 1;
    cycle();
    idle();

    // LL
    bus.ll_valid = 1; bus.ll_addr = 32'hABCD1234;
    cycle();
    idle();
    read_chk("lladdr", 5'd17, 3'd0, 32'h0ABCD123);

    // interrupt
    mtc0(5'd12, 3'd0, 32'h00000401);
    chk("irq_off", 32'(bus.irq_pending), 32'h0);
    bus.hw_irq = 6'b000001;
    cycle();
    cycle();
    chk("irq_on", 32'(bus.irq_pending), 32'h1);
    bus.hw_irq = 0;
    cycle();

    // reset in the middle of a timer run
    mtc0(5'd11, 3'd0, 32'd10);
    mtc0(5'd9, 3'd0, 32'd7);
    cycle();
    cycle();
    bus.rd = 5'd9; bus.sel = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_status", bus.status_o, 32'h00400004);
    chk("mrst_ebase",  bus.ebase_o,  32'h80000000);
    chk("mrst_cause",  bus.cause_o,  32'h0);
    chk("mrst_epc",    bus.epc_o,    32'h0);
    chk("mrst_count",  bus.rdata,    32'h0);
    chk("mrst_irq",    32'(bus.irq_pending), 32'h0);
    m_reset();
    cycle();
    reset = 1'b0;

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      idle();
      pr = pairs[$urandom_range(0, 9)];
      bus.rd  = pr[7:3];
      bus.sel = pr[2:0];
      if ($urandom_range(0, 9) == 0) begin
        bus.rd  = 5'($urandom);
        bus.sel = 3'($urandom);
      end
      bus.we    = ($urandom_range(0, 3) == 0);
      bus.wdata = $urandom;
      if (bus.we && bus.rd == 5'd9 && bus.sel == 3'd0 && $urandom_range(0, 1) == 1)
        bus.wdata = m_cmp - 32'($urandom_range(1, 4));
      bus.exc_valid     = ($urandom_range(0, 15) == 0);
      bus.exc_code      = 5'($urandom);
      bus.exc_bd        = 1'($urandom);
      bus.exc_epc       = $urandom;
      bus.exc_bva_valid = 1'($urandom);
      bus.exc_bva       = $urandom;
      bus.eret          = !bus.we && ($urandom_range(0, 11) == 0);
      if (bus.exc_valid && $urandom_range(0, 3) == 0) bus.eret = 1'b1;
      bus.ll_valid      = ($urandom_range(0, 7) == 0);
      bus.ll_addr       = $urandom;
      if ($urandom_range(0, 7) == 0) bus.hw_irq = 6'($urandom);
      if (i == 1500) begin
        reset = 1'b1;
        m_reset();
        cycle();
        reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
